// File: rtl/riscy_pkg.sv
// Shared decode vocabulary for the riscy core: ALU op codes, RV32I field
// constants, the decoded-instruction bundle and the decoder itself.
package riscy_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef struct packed {
    logic      legal;
    logic      use_imm;
    logic      rs2_used;
    alu_ctrl_e ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
  } decoded_t;

  function automatic decoded_t decode_instr(input logic [31:0] instr);
    decoded_t   d;
    logic [6:0] f7;
    logic [2:0] f3;
    f7         = instr[31:25];
    f3         = instr[14:12];
    d.legal    = 1'b0;
    d.use_imm  = 1'b0;
    d.rs2_used = 1'b0;
    d.ctrl     = ALU_ADD;
    d.rs1      = instr[19:15];
    d.rs2      = instr[24:20];
    d.rd       = instr[11:7];
    d.imm      = {{20{instr[31]}}, instr[31:20]};
    if (instr[6:0] == OPC_OP) begin
      d.rs2_used = 1'b1;
      case (f3)
        F3_ADD: begin
          d.legal = (f7 == F7_BASE) || (f7 == F7_SUB);
          d.ctrl  = (f7 == F7_SUB) ? ALU_SUB : ALU_ADD;
        end
        F3_SLT:  begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_SLT; end
        F3_OR:   begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_OR;  end
        F3_AND:  begin d.legal = (f7 == F7_BASE); d.ctrl = ALU_AND; end
        default: d.legal = 1'b0;
      endcase
    end else if (instr[6:0] == OPC_OP_IMM) begin
      d.use_imm = 1'b1;
      case (f3)
        F3_ADD:  begin d.legal = 1'b1; d.ctrl = ALU_ADD; end
        F3_SLT:  begin d.legal = 1'b1; d.ctrl = ALU_SLT; end
        F3_OR:   begin d.legal = 1'b1; d.ctrl = ALU_OR;  end
        F3_AND:  begin d.legal = 1'b1; d.ctrl = ALU_AND; end
        default: d.legal = 1'b0;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file: two asynchronous read ports with write-back bypass,
// one write port, x0 hardwired to zero.
module regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  // A write landing this cycle is forwarded so dependent reads see it now.
  always_comb begin
    rdata1 = mem[raddr1];
    if (raddr1 == '0)                  rdata1 = '0;
    else if (we && (waddr == raddr1))  rdata1 = wdata;
  end

  always_comb begin
    rdata2 = mem[raddr2];
    if (raddr2 == '0)                  rdata2 = '0;
    else if (we && (waddr == raddr2))  rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: decodes RV32I ALU ops, reads operands, tracks
// outstanding writes in a pending scoreboard and stalls on RAW/WAW hazards.
module decode_stage
  import riscy_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [2:0]      ex_ctrl,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  decoded_t        dec;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [NREGS-1:0] pending, pending_next;
  logic            haz_rs1, haz_rs2, haz_rd, hazard, accept;

  logic            ex_valid_p1, ex_we_p1, illegal_p1;
  logic [XLEN-1:0] ex_rs1_p1, ex_rs2_p1;
  alu_ctrl_e       ex_ctrl_p1;
  logic [4:0]      ex_rd_p1;

  assign dec = decode_instr(instr);

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data),
    .raddr1 (dec.rs1),
    .raddr2 (dec.rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // A write-back returning this cycle releases its register with no bubble.
  assign haz_rs1 = dec.legal && (dec.rs1 != '0) && pending[dec.rs1]
                   && !(wb_we && (wb_addr == dec.rs1));
  assign haz_rs2 = dec.legal && dec.rs2_used && (dec.rs2 != '0) && pending[dec.rs2]
                   && !(wb_we && (wb_addr == dec.rs2));
  assign haz_rd  = dec.legal && (dec.rd != '0) && pending[dec.rd]
                   && !(wb_we && (wb_addr == dec.rd));
  assign hazard  = instr_valid && (haz_rs1 || haz_rs2 || haz_rd);

  assign instr_ready = (!ex_valid_p1 || ex_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Set is applied after clear so a same-cycle set/clear leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (wb_we) pending_next[wb_addr] = 1'b0;
    if (accept && dec.legal) pending_next[dec.rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // ---- stage p1: registered operand bundle toward the ALU ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_p1 <= 1'b0;
      ex_rs1_p1   <= '0;
      ex_rs2_p1   <= '0;
      ex_ctrl_p1  <= ALU_ADD;
      ex_rd_p1    <= '0;
      ex_we_p1    <= 1'b0;
      illegal_p1  <= 1'b0;
      pending     <= '0;
    end else begin
      pending    <= pending_next;
      illegal_p1 <= accept && !dec.legal;
      if (accept && dec.legal) begin
        ex_valid_p1 <= 1'b1;
        ex_rs1_p1   <= rs1_val;
        ex_rs2_p1   <= dec.use_imm ? dec.imm : rs2_val;
        ex_ctrl_p1  <= dec.ctrl;
        ex_rd_p1    <= dec.rd;
        ex_we_p1    <= (dec.rd != '0);
      end else if (ex_ready) begin
        ex_valid_p1 <= 1'b0;
      end
    end
  end

  assign ex_valid = ex_valid_p1;
  assign ex_rs1   = ex_rs1_p1;
  assign ex_rs2   = ex_rs2_p1;
  assign ex_ctrl  = ex_ctrl_p1;
  assign ex_rd    = ex_rd_p1;
  assign ex_we    = ex_we_p1;
  assign illegal  = illegal_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic scored against an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, instr_valid, ex_ready, wb_we;
  logic [31:0] instr, wb_data;
  logic [4:0]  wb_addr;
  logic        instr_ready, ex_valid, ex_we, illegal;
  logic [31:0] ex_rs1, ex_rs2;
  logic [2:0]  ex_ctrl;
  logic [4:0]  ex_rd;
  logic [73:0] bundle;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_ctrl(ex_ctrl), .ex_rd(ex_rd),
    .ex_we(ex_we), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .illegal(illegal)
  );

  assign bundle = {ex_valid, ex_rs1, ex_rs2, ex_ctrl, ex_rd, ex_we};

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  bit          m_pend [32];
  bit          m_valid, m_we, m_ill;
  logic [31:0] m_rs1, m_rs2;
  logic [2:0]  m_ctrl;
  logic [4:0]  m_rd;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Instruction table: mnemonic -> ALU op, straight from the ISA subset.
  function automatic void ref_decode(input logic [31:0] ins, output bit legal,
                                     output bit imm_form, output logic [2:0] op);
    legal = 0; imm_form = 0; op = 3'b000;
    if (ins[6:0] == 7'h33) begin
      case ({ins[31:25], ins[14:12]})
        10'b0000000_000: begin legal = 1; op = 3'b000; end
        10'b0100000_000: begin legal = 1; op = 3'b001; end
        10'b0000000_010: begin legal = 1; op = 3'b101; end
        10'b0000000_110: begin legal = 1; op = 3'b011; end
        10'b0000000_111: begin legal = 1; op = 3'b010; end
        default: ;
      endcase
    end else if (ins[6:0] == 7'h13) begin
      imm_form = 1;
      case (ins[14:12])
        3'b000: begin legal = 1; op = 3'b000; end
        3'b010: begin legal = 1; op = 3'b101; end
        3'b110: begin legal = 1; op = 3'b011; end
        3'b111: begin legal = 1; op = 3'b010; end
        default: ;
      endcase
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (wb_we && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic bit blocked(input logic [4:0] r);
    return (r != 0) && m_pend[r] && !(wb_we && wb_addr == r);
  endfunction

  function automatic bit model_ready();
    bit legal, imf;
    logic [2:0] op;
    bit haz;
    ref_decode(instr, legal, imf, op);
    haz = instr_valid && legal && (blocked(instr[19:15]) || (!imf && blocked(instr[24:20]))
                                   || blocked(instr[11:7]));
    return !(m_valid && !ex_ready) && !haz;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_pend[i] = 0; end
    m_valid = 0; m_we = 0; m_ill = 0; m_rs1 = 0; m_rs2 = 0; m_ctrl = 0; m_rd = 0;
  endtask

  task automatic model_clock();
    bit legal, imf, acc;
    logic [2:0] op;
    logic [31:0] a, b;
    logic [4:0] rd;
    ref_decode(instr, legal, imf, op);
    acc = instr_valid && model_ready();
    rd  = instr[11:7];
    a   = model_read(instr[19:15]);
    b   = imf ? {{20{instr[31]}}, instr[31:20]} : model_read(instr[24:20]);
    m_ill = acc && !legal;
    if (acc && legal) begin
      m_valid = 1; m_rs1 = a; m_rs2 = b; m_ctrl = op; m_rd = rd; m_we = (rd != 0);
    end else if (ex_ready) begin
      m_valid = 0;
    end
    if (wb_we) begin
      if (wb_addr != 0) m_rf[wb_addr] = wb_data;
      m_pend[wb_addr] = 0;
    end
    if (acc && legal && rd != 0) m_pend[rd] = 1;
  endtask

  task automatic tick();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_cycle(input logic [4:0] a, input logic [31:0] d);
    instr_valid = 0; wb_we = 1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1; instr_valid = 0; instr = 0; ex_ready = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
    model_reset();
    @(posedge clk); #1; @(posedge clk); #1;
    rst = 0;
    #2;
    n_tests++; if (bundle !== 74'd0 || illegal !== 1'b0) begin n_fail++;
      $display("FAIL reset_outputs: got %h/%b expected 0/0", bundle, illegal); end
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_addi();
    instr_valid = 1; instr = 32'h00500093; ex_ready = 1;
    #2;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL addi_ready: got %b expected 1", instr_ready); end
    tick();
    n_tests++; if (bundle !== {1'b1, 32'd0, 32'd5, 3'b000, 5'd1, 1'b1}) begin n_fail++;
      $display("FAIL addi_bundle: got %h expected %h", bundle, {1'b1, 32'd0, 32'd5, 3'b000, 5'd1, 1'b1}); end
    instr_valid = 0;
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL addi_drain: got %b expected 0", ex_valid); end
  endtask

  task automatic test_raw_bypass();
    instr_valid = 1; instr = r_type(7'h00, 3'b000, 5'd2, 5'd1, 5'd1); ex_ready = 1;
    #2;
    n_tests++; if (instr_ready !== 1'b0) begin n_fail++;
      $display("FAIL raw_stall: got %b expected 0", instr_ready); end
    wb_we = 1; wb_addr = 1; wb_data = 5;
    #1;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL raw_release: got %b expected 1", instr_ready); end
    tick();
    wb_we = 0;
    n_tests++; if (bundle !== {1'b1, 32'd5, 32'd5, 3'b000, 5'd2, 1'b1}) begin n_fail++;
      $display("FAIL raw_bypass: got %h expected %h", bundle, {1'b1, 32'd5, 32'd5, 3'b000, 5'd2, 1'b1}); end
  endtask

  task automatic test_sub_slt();
    wb_cycle(3, 8); wb_cycle(4, 3); wb_cycle(2, 0);
    instr_valid = 1; instr = r_type(7'h20, 3'b000, 5'd5, 5'd3, 5'd4);
    #2;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL sub_ready: got %b expected 1", instr_ready); end
    tick();
    n_tests++; if (bundle !== {1'b1, 32'd8, 32'd3, 3'b001, 5'd5, 1'b1}) begin n_fail++;
      $display("FAIL sub_bundle: got %h expected %h", bundle, {1'b1, 32'd8, 32'd3, 3'b001, 5'd5, 1'b1}); end
    instr = i_type(12'hFFF, 3'b010, 5'd6, 5'd3);
    #2;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL slti_b2b_ready: got %b expected 1", instr_ready); end
    tick();
    n_tests++; if (bundle !== {1'b1, 32'd8, 32'hFFFFFFFF, 3'b101, 5'd6, 1'b1}) begin n_fail++;
      $display("FAIL slti_bundle: got %h expected %h", bundle, {1'b1, 32'd8, 32'hFFFFFFFF, 3'b101, 5'd6, 1'b1}); end
    wb_cycle(5, 0); wb_cycle(6, 0);
  endtask

  task automatic test_backpressure();
    logic [73:0] held;
    held = {1'b1, 32'd8, 32'd3, 3'b011, 5'd7, 1'b1};
    ex_ready = 1; instr_valid = 1; instr = r_type(7'h00, 3'b110, 5'd7, 5'd3, 5'd4);
    tick();
    ex_ready = 0; instr = r_type(7'h00, 3'b111, 5'd8, 5'd3, 5'd4);
    for (int i = 0; i < 3; i++) begin
      #2;
      n_tests++; if (instr_ready !== 1'b0) begin n_fail++;
        $display("FAIL bp_ready[%0d]: got %b expected 0", i, instr_ready); end
      tick();
      n_tests++; if (bundle !== held) begin n_fail++;
        $display("FAIL bp_hold[%0d]: got %h expected %h", i, bundle, held); end
    end
    ex_ready = 1;
    #2;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL bp_resume_ready: got %b expected 1", instr_ready); end
    tick();
    n_tests++; if (bundle !== {1'b1, 32'd8, 32'd3, 3'b010, 5'd8, 1'b1}) begin n_fail++;
      $display("FAIL bp_next: got %h expected %h", bundle, {1'b1, 32'd8, 32'd3, 3'b010, 5'd8, 1'b1}); end
    instr_valid = 0;
    tick();
    n_tests++; if (ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL bp_drain: got %b expected 0", ex_valid); end
    wb_cycle(7, 0); wb_cycle(8, 0);
  endtask

  task automatic test_illegal();
    ex_ready = 1; instr_valid = 1; instr = r_type(7'h00, 3'b100, 5'd1, 5'd2, 5'd3);
    #2;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL ill_ready: got %b expected 1", instr_ready); end
    tick();
    n_tests++; if ({illegal, ex_valid} !== 2'b10) begin n_fail++;
      $display("FAIL ill_pulse: got %b%b expected 10", illegal, ex_valid); end
    instr = r_type(7'h00, 3'b000, 5'd2, 5'd1, 5'd1);
    #2;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL ill_no_pending: got %b expected 1", instr_ready); end
    instr_valid = 0;
    tick();
    n_tests++; if (illegal !== 1'b0) begin n_fail++;
      $display("FAIL ill_one_cycle: got %b expected 0", illegal); end
  endtask

  task automatic test_x0_reset();
    ex_ready = 1; instr_valid = 1; instr = r_type(7'h00, 3'b000, 5'd0, 5'd1, 5'd2);
    tick();
    n_tests++; if (bundle !== {1'b1, 32'd5, 32'd0, 3'b000, 5'd0, 1'b0}) begin n_fail++;
      $display("FAIL x0_dest: got %h expected %h", bundle, {1'b1, 32'd5, 32'd0, 3'b000, 5'd0, 1'b0}); end
    instr = r_type(7'h00, 3'b000, 5'd9, 5'd0, 5'd0);
    #2;
    n_tests++; if (instr_ready !== 1'b1) begin n_fail++;
      $display("FAIL x0_no_stall: got %b expected 1", instr_ready); end
    tick();
    instr = 32'h00500093;
    tick();
    n_tests++; if (bundle !== {1'b1, 32'd0, 32'd5, 3'b000, 5'd1, 1'b1}) begin n_fail++;
      $display("FAIL pre_rst_bundle: got %h expected %h", bundle, {1'b1, 32'd0, 32'd5, 3'b000, 5'd1, 1'b1}); end
    ex_ready = 0; instr = r_type(7'h00, 3'b000, 5'd2, 5'd1, 5'd1);
    #2;
    n_tests++; if (instr_ready !== 1'b0) begin n_fail++;
      $display("FAIL pre_rst_stall: got %b expected 0", instr_ready); end
    rst = 1;
    ex_ready = 1;
    #1;
    model_reset();
    n_tests++; if ({ex_valid, instr_ready} !== 2'b01) begin n_fail++;
      $display("FAIL async_rst: got valid/ready %b%b expected 01", ex_valid, instr_ready); end
    rst = 0; instr_valid = 0;
    @(posedge clk); #1;
    wb_cycle(1, 77);
    instr_valid = 1;
    tick();
    n_tests++; if (bundle !== {1'b1, 32'd77, 32'd77, 3'b000, 5'd2, 1'b1}) begin n_fail++;
      $display("FAIL post_rst_wb: got %h expected %h", bundle, {1'b1, 32'd77, 32'd77, 3'b000, 5'd2, 1'b1}); end
    wb_cycle(2, 0);
  endtask

  task automatic test_random();
    logic [9:0] rtab [5];
    logic [2:0] itab [4];
    logic [9:0] sel;
    int k, start;
    rtab[0] = 10'b0000000_000; rtab[1] = 10'b0100000_000; rtab[2] = 10'b0000000_010;
    rtab[3] = 10'b0000000_110; rtab[4] = 10'b0000000_111;
    itab[0] = 3'b000; itab[1] = 3'b010; itab[2] = 3'b110; itab[3] = 3'b111;
    for (int c = 0; c < 400; c++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        sel = rtab[$urandom_range(0, 4)];
        instr = r_type(sel[9:3], sel[2:0], 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end else if (k < 8) begin
        instr = i_type(12'($urandom), itab[$urandom_range(0, 3)],
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end else if (k == 8) begin
        instr = r_type(7'h00, 3'b100, 5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end else begin
        instr = $urandom;
      end
      instr_valid = ($urandom_range(0, 3) != 0);
      ex_ready    = ($urandom_range(0, 3) != 0);
      wb_we       = ($urandom_range(0, 2) != 0);
      wb_data     = $urandom;
      wb_addr     = 5'($urandom_range(0, 7));
      start = $urandom_range(1, 7);
      for (int j = 0; j < 7; j++) begin
        if (m_pend[((start + j) % 7) + 1]) wb_addr = 5'(((start + j) % 7) + 1);
      end
      #2;
      n_tests++; if (instr_ready !== model_ready()) begin n_fail++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", c, instr_ready, model_ready()); end
      tick();
      n_tests++; if (bundle !== {m_valid, m_rs1, m_rs2, m_ctrl, m_rd, m_we} || illegal !== m_ill) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: got %h/%b expected %h/%b", c, bundle, illegal,
                 {m_valid, m_rs1, m_rs2, m_ctrl, m_rd, m_we}, m_ill);
      end
    end
    instr_valid = 0; wb_we = 0;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_raw_bypass();
    test_sub_slt();
    test_backpressure();
    test_illegal();
    test_x0_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
